vend: RTL and testbench
=======================

Name: vend

Overview:
- Newspaper vending-machine controller; newspaper price is 15 cents.
- Accepts one coin per clock cycle: nickel (5 cents) or dime (10 cents).
- Accumulates credit in a four-state FSM and pulses `newspaper` for one cycle once 15 cents or more has been inserted.
- Leaf block between coin-acceptor logic and the dispenser actuator; no change-return path.

Parameters:
- None. Fixed constants:
  - price 15 cents
  - coin encoding 2'd0 = none, 2'd1 = nickel, 2'd2 = dime, 2'd3 = invalid

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- coin  input  2  coin inserted this cycle: 0 none, 1 nickel, 2 dime, 3 invalid (treated as none)
- newspaper  output  1  dispense strobe; high for exactly one clock cycle per sale

Port order at instantiation: coin, clock, reset, newspaper.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- `coin` is sampled only on the rising edge of `clock`. The upstream acceptor holds a coin value for exactly one cycle per coin. A value held N cycles counts as N coins.
- States (2-bit encoding):
  - S0 = 0 cents
  - S5 = 5 cents
  - S10 = 10 cents
  - S15 = paid, dispensing
- Transitions on each rising edge, when reset = 0:
  - S0: nickel -> S5; dime -> S10; none/invalid -> S0.
  - S5: nickel -> S10; dime -> S15; none/invalid -> S5.
  - S10: nickel -> S15; dime -> S15 (20 cents accepted, no change, excess credit discarded); none/invalid -> S10.
  - S15: unconditionally -> S0.
- Coin received while in S15 is ignored and lost; no credit is carried into S0.
- Output: `newspaper` = 1 exactly when state == S15. This is a Moore output decoded from the state register; no combinational path from `coin` to `newspaper`.
- Latency: `newspaper` rises one cycle after the edge that samples the completing coin. It stays high for one full cycle, then falls.
- Reset:
  - `reset` = 1 at a rising edge forces state to S0, so `newspaper` = 0 after that edge.
  - Reset has priority over any coin in the same cycle.
  - Reset mid-transaction (S5/S10/S15) discards accumulated credit; a pending dispense in S15 is cancelled.
- Power-up state before the first reset is undefined. The bench must assert reset for at least one clock edge.
- Any unreachable or illegal state encoding recovers to S0 on the next edge, with `newspaper` = 0.
- Idle: with `coin` = 0, the state holds indefinitely; credit never times out.

Test Plan:
- Reset: reset = 1 for 2 cycles with coin = 1 -> state S0, newspaper = 0 throughout. After release, coin = 0 for 5 cycles -> newspaper stays 0.
- Three nickels: coin = 1 for one cycle, then idle 2 cycles, repeated 3 times -> newspaper = 0 until the cycle after the third nickel, high exactly 1 cycle, then 0.
- Nickel then dime: coin = 1 (1 cycle), idle, coin = 2 (1 cycle) -> single 1-cycle newspaper pulse after the dime; next sale starts from 0 (one dime alone gives no pulse).
- Two dimes: coin = 2, idle, coin = 2 -> one 1-cycle pulse; no residual credit (a following single nickel gives no pulse).
- Dime then nickel, then back-to-back coins:
  - coin = 2 then coin = 1 -> one pulse.
  - coin = 1 for 3 consecutive cycles -> pulse in the cycle after the third coin.
  - A coin applied while newspaper = 1 is ignored: total remains one pulse, state returns to S0.
- Invalid code and reset mid-operation:
  - coin = 3 in S5 -> stays S5.
  - Insert dime (S10), assert reset with coin = 1 in the same cycle -> S0, no pulse.
  - A subsequent nickel -> S5, no pulse.

Source files
------------

// File: rtl/vend.sv
// Newspaper vending controller: sums nickels/dimes up to 15 cents and
// raises a one-cycle Moore dispense strobe. Overpayment is not refunded.
module vend (
  input  logic [1:0] coin,
  input  logic       clock,
  input  logic       reset,
  output logic       newspaper
);

  typedef enum logic [1:0] {
    S0  = 2'd0,
    S5  = 2'd1,
    S10 = 2'd2,
    S15 = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NICKEL = 2'd1;
  localparam logic [1:0] COIN_DIME   = 2'd2;

  state_t state, state_nxt;

  always_ff @(posedge clock) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S0;
    unique case (state)
      S0: begin
        if      (coin == COIN_NICKEL) state_nxt = S5;
        else if (coin == COIN_DIME)   state_nxt = S10;
        else                          state_nxt = S0;
      end
      S5: begin
        if      (coin == COIN_NICKEL) state_nxt = S10;
        else if (coin == COIN_DIME)   state_nxt = S15;
        else                          state_nxt = S5;
      end
      S10: begin
        // a dime here reaches 20 cents; the extra nickel of credit is dropped
        if (coin == COIN_NICKEL || coin == COIN_DIME) state_nxt = S15;
        else                                          state_nxt = S10;
      end
      S15:     state_nxt = S0;  // coin arriving during dispense is lost
      default: state_nxt = S0;
    endcase
  end

  assign newspaper = (state == S15);

endmodule

// File: tb/tb_vend.sv
// Directed bench for vend: each step drives coin/reset for one edge and
// checks the newspaper strobe just after that edge.
module tb_vend;

  logic [1:0] coin;
  logic       clock;
  logic       reset;
  logic       newspaper;

  int total = 0;
  int bad   = 0;

  vend dut (
    .coin      (coin),
    .clock     (clock),
    .reset     (reset),
    .newspaper (newspaper)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // apply coin/reset across one rising edge, then check the Moore output
  task automatic step(input string tag, input logic [1:0] c, input logic r,
                      input logic exp);
    coin  = c;
    reset = r;
    @(posedge clock);
    #1;
    chk(tag, newspaper, exp);
  endtask

  initial begin
    coin  = 2'd0;
    reset = 1'b1;
    @(negedge clock);

    // reset with a coin present: reset wins
    step("rst0", 2'd1, 1'b1, 1'b0);
    step("rst1", 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("idle", 2'd0, 1'b0, 1'b0);

    // three nickels with idle gaps
    step("n1", 2'd1, 1'b0, 1'b0);
    step("n1i", 2'd0, 1'b0, 1'b0);
    step("n1i", 2'd0, 1'b0, 1'b0);
    step("n2", 2'd1, 1'b0, 1'b0);
    step("n2i", 2'd0, 1'b0, 1'b0);
    step("n2i", 2'd0, 1'b0, 1'b0);
    step("n3", 2'd1, 1'b0, 1'b1);
    step("n3f", 2'd0, 1'b0, 1'b0);
    step("n3f", 2'd0, 1'b0, 1'b0);

    // nickel then dime; then a lone dime gives nothing
    step("nd_n", 2'd1, 1'b0, 1'b0);
    step("nd_i", 2'd0, 1'b0, 1'b0);
    step("nd_d", 2'd2, 1'b0, 1'b1);
    step("nd_f", 2'd0, 1'b0, 1'b0);
    step("d_alone", 2'd2, 1'b0, 1'b0);
    step("d_alone_i", 2'd0, 1'b0, 1'b0);
    step("clr", 2'd0, 1'b1, 1'b0);

    // two dimes; no residual credit afterwards
    step("dd_d1", 2'd2, 1'b0, 1'b0);
    step("dd_i", 2'd0, 1'b0, 1'b0);
    step("dd_d2", 2'd2, 1'b0, 1'b1);
    step("dd_f", 2'd0, 1'b0, 1'b0);
    step("dd_n", 2'd1, 1'b0, 1'b0);
    step("dd_ni", 2'd0, 1'b0, 1'b0);
    step("clr", 2'd0, 1'b1, 1'b0);

    // dime then nickel
    step("dn_d", 2'd2, 1'b0, 1'b0);
    step("dn_n", 2'd1, 1'b0, 1'b1);
    step("dn_f", 2'd0, 1'b0, 1'b0);

    // back-to-back nickels, then a coin during the strobe is lost
    step("bb1", 2'd1, 1'b0, 1'b0);
    step("bb2", 2'd1, 1'b0, 1'b0);
    step("bb3", 2'd1, 1'b0, 1'b1);
    step("bb_lost", 2'd2, 1'b0, 1'b0);
    step("bb_idle", 2'd0, 1'b0, 1'b0);
    // three more nickels needed: proves state returned to S0
    step("bb_s0a", 2'd1, 1'b0, 1'b0);
    step("bb_s0b", 2'd1, 1'b0, 1'b0);
    step("bb_s0c", 2'd1, 1'b0, 1'b1);
    step("bb_f", 2'd0, 1'b0, 1'b0);

    // invalid code holds S5
    step("inv_n", 2'd1, 1'b0, 1'b0);
    step("inv3a", 2'd3, 1'b0, 1'b0);
    step("inv3b", 2'd3, 1'b0, 1'b0);
    step("inv_d", 2'd2, 1'b0, 1'b1);
    step("inv_f", 2'd0, 1'b0, 1'b0);

    // reset in S10 with a nickel present: credit discarded
    step("rm_d", 2'd2, 1'b0, 1'b0);
    step("rm_rst", 2'd1, 1'b1, 1'b0);
    step("rm_n1", 2'd1, 1'b0, 1'b0);
    step("rm_i", 2'd0, 1'b0, 1'b0);
    step("rm_n2", 2'd1, 1'b0, 1'b0);
    step("rm_n3", 2'd1, 1'b0, 1'b1);
    step("rm_f", 2'd0, 1'b0, 1'b0);

    // reset in S5 then dime: only 10 cents
    step("r5_n", 2'd1, 1'b0, 1'b0);
    step("r5_rst", 2'd0, 1'b1, 1'b0);
    step("r5_d", 2'd2, 1'b0, 1'b0);
    step("r5_i", 2'd0, 1'b0, 1'b0);

    // reset while dispensing cancels the strobe
    step("r15_n", 2'd1, 1'b0, 1'b1);
    step("r15_rst", 2'd0, 1'b1, 1'b0);
    step("r15_i", 2'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
